// File: rtl/serial_addsub_unit.sv
// Digit-serial add/subtract unit.
// Processes DIGIT bits per clock, LSB digit first, over N = WIDTH/DIGIT RUN
// cycles, then spends one FIX cycle turning the raw two's-complement result
// into a magnitude plus sign (subtract) or sum plus carry (add).
//
// Handshake: an operation is accepted on a rising edge where start=1 and
// ready=1. ready is high in IDLE and DONE, so a new operation may be issued
// in the same cycle the previous result is presented (done=1). start while
// busy=1 is ignored. done is a one-cycle pulse. q/neg/c_out are valid while
// done=1, and they keep that value until the next FIX edge or reset.
module serial_addsub_unit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             neg,
  output logic             c_out,
  output logic [1:0]       fsm_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] raw;
  logic             mode_r;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   psum;
  logic             accept;
  int               idx;

  assign ready     = (state == IDLE) || (state == DONE);
  assign busy      = (state == RUN) || (state == FIX);
  assign done      = (state == DONE);
  assign accept    = start && ready;
  assign fsm_state = state;

  // Current digit slice and its sum; B is inverted in subtract mode so that
  // carry-in of 1 on the first digit yields A + ~B + 1 = A - B.
  always_comb begin
    idx   = int'(cnt) * DIGIT;
    a_dig = a_r[idx +: DIGIT];
    b_dig = mode_r ? ~b_r[idx +: DIGIT] : b_r[idx +: DIGIT];
    psum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
  end

  // Control FSM, operand latches, digit datapath and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      raw    <= '0;
      mode_r <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      q      <= '0;
      neg    <= 1'b0;
      c_out  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_r    <= a;
            b_r    <= b;
            mode_r <= mode;
            cnt    <= '0;
            carry  <= mode;
            state  <= RUN;
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        RUN: begin
          raw[idx +: DIGIT] <= psum[DIGIT-1:0];
          carry             <= psum[DIGIT];
          if (cnt == CW'(N - 1)) begin
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (!mode_r) begin
            q     <= raw;
            neg   <= 1'b0;
            c_out <= carry;
          end else if (carry) begin
            // No borrow: A >= B, raw difference is already the magnitude.
            q     <= raw;
            neg   <= 1'b0;
            c_out <= 1'b0;
          end else begin
            // Borrow: A < B, negate to get B - A.
            q     <= ~raw + WIDTH'(1);
            neg   <= 1'b1;
            c_out <= 1'b0;
          end
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Testbench for serial_addsub_unit: a WIDTH=16/DIGIT=4 instance and a
// WIDTH=8/DIGIT=8 instance, random and directed operations, scoreboard
// queues filled by the drivers and drained by per-instance monitors.
module tb_serial_addsub_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // ---------------- DUT 0: 16/4 ----------------
  logic        start0 = 1'b0, mode0 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0, q0;
  logic        ready0, busy0, done0, neg0, cout0;
  logic [1:0]  st0;

  serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode0), .a(a0), .b(b0),
    .ready(ready0), .busy(busy0), .done(done0), .q(q0), .neg(neg0),
    .c_out(cout0), .fsm_state(st0)
  );

  // ---------------- DUT 1: 8/8 ----------------
  logic       start1 = 1'b0, mode1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0, q1;
  logic       ready1, busy1, done1, neg1, cout1;
  logic [1:0] st1;

  serial_addsub_unit #(.WIDTH(8), .DIGIT(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .a(a1), .b(b1),
    .ready(ready1), .busy(busy1), .done(done1), .q(q1), .neg(neg1),
    .c_out(cout1), .fsm_state(st1)
  );

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];   // {q, neg, c_out}
  int          exp_t[$];   // cycle count at accept
  logic [9:0]  exp1_q[$];
  int          exp1_t[$];
  logic [17:0] last0 = '0;
  logic [9:0]  last1 = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input int w, input bit m,
                                input longint unsigned x, input longint unsigned y,
                                output longint unsigned rq, output bit rn, output bit rc);
    longint unsigned mask;
    longint unsigned s;
    mask = (64'd1 << w) - 1;
    rn = 1'b0;
    rc = 1'b0;
    if (!m) begin
      s  = x + y;
      rq = s & mask;
      rc = ((s >> w) & 1) != 0;
    end else if (x >= y) begin
      rq = x - y;
    end else begin
      rq = y - x;
      rn = 1'b1;
    end
  endfunction

  // Monitor for DUT 0
  always @(negedge clk) begin
    if (mon_en) begin
      if (done0) begin
        if (exp_q.size() == 0) begin
          chk("u0_spurious_done", 1, 0);
        end else begin
          logic [17:0] e;
          int t;
          e = exp_q.pop_front();
          t = exp_t.pop_front();
          chk("u0_result", {q0, neg0, cout0}, e);
          chk("u0_latency", cyc - t, 5);
          last0 = e;
        end
      end else begin
        chk("u0_hold", {q0, neg0, cout0}, last0);
      end
      if (!rst_n) begin
        exp_q.delete();
        exp_t.delete();
        last0 = '0;
      end
    end
  end

  // Monitor for DUT 1
  always @(negedge clk) begin
    if (mon_en) begin
      if (done1) begin
        if (exp1_q.size() == 0) begin
          chk("u1_spurious_done", 1, 0);
        end else begin
          logic [9:0] e;
          int t;
          e = exp1_q.pop_front();
          t = exp1_t.pop_front();
          chk("u1_result", {q1, neg1, cout1}, e);
          chk("u1_latency", cyc - t, 2);
          last1 = e;
        end
      end else begin
        chk("u1_hold", {q1, neg1, cout1}, last1);
      end
      if (!rst_n) begin
        exp1_q.delete();
        exp1_t.delete();
        last1 = '0;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_rdy0();
    int n = 0;
    while (!ready0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready0) chk("u0_ready_timeout", 0, 1);
  endtask

  task automatic wait_rdy1();
    int n = 0;
    while (!ready1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready1) chk("u1_ready_timeout", 0, 1);
  endtask

  // Issue one operation; with hold=1 keep start high and scramble the inputs
  // for as long as the unit is busy.
  task automatic do_op0(input bit m, input logic [15:0] x, input logic [15:0] y, input bit hold);
    longint unsigned rq;
    bit rn, rc;
    wait_rdy0();
    mode0  = m;
    a0     = x;
    b0     = y;
    start0 = 1'b1;
    model(16, m, x, y, rq, rn, rc);
    exp_q.push_back({rq[15:0], rn, rc});
    exp_t.push_back(cyc + 1);
    @(posedge clk); #1;
    if (hold) begin
      int n = 0;
      while (busy0 && n < 50) begin
        start0 = 1'b1;
        a0     = 16'($urandom);
        b0     = 16'($urandom);
        mode0  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        n++;
      end
    end
    start0 = 1'b0;
  endtask

  task automatic do_op1(input bit m, input logic [7:0] x, input logic [7:0] y);
    longint unsigned rq;
    bit rn, rc;
    wait_rdy1();
    mode1  = m;
    a1     = x;
    b1     = y;
    start1 = 1'b1;
    model(8, m, x, y, rq, rn, rc);
    exp1_q.push_back({rq[7:0], rn, rc});
    exp1_t.push_back(cyc + 1);
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  // Subtract accepted, reset asserted so it is sampled on the 2nd RUN edge,
  // held for two edges; the operation must vanish without a done pulse.
  task automatic reset_mid_run();
    wait_rdy0();
    mode0  = 1'b1;
    a0     = 16'h1234;
    b0     = 16'h0001;
    start0 = 1'b1;
    @(posedge clk); #1;   // accept edge
    start0 = 1'b0;
    @(posedge clk); #1;   // 1st RUN edge
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid_q", q0, 0);
    chk("rst_mid_neg", neg0, 0);
    chk("rst_mid_cout", cout0, 0);
    chk("rst_mid_ready", ready0, 1);
    chk("rst_mid_busy", busy0, 0);
    chk("rst_mid_done", done0, 0);
    repeat (8) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_q", q0, 0);
    chk("reset_neg", neg0, 0);
    chk("reset_cout", cout0, 0);
    chk("reset_done", done0, 0);
    chk("reset_ready", ready0, 1);
    chk("reset_busy", busy0, 0);
    chk("reset_q1", q1, 0);
    chk("reset_ready1", ready1, 1);
    mon_en = 1'b1;

    // Directed cases, issued back-to-back.
    do_op0(1'b1, 16'h0064, 16'h0019, 1'b0);
    do_op0(1'b1, 16'h0019, 16'h0064, 1'b0);
    do_op0(1'b1, 16'h1234, 16'h1234, 1'b0);
    do_op0(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    do_op0(1'b0, 16'h00FF, 16'h0001, 1'b0);
    do_op0(1'b1, 16'h0000, 16'hFFFF, 1'b0);

    // start held through busy with changing operands.
    do_op0(1'b1, 16'h0500, 16'h0123, 1'b1);
    do_op0(1'b0, 16'h8001, 16'h8002, 1'b1);

    reset_mid_run();

    // Random operations with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] x, y;
      x = 16'($urandom);
      y = ($urandom_range(0, 4) == 0) ? x : 16'($urandom);
      do_op0(1'($urandom_range(0, 1)), x, y, 1'($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end

    // Single-digit instance.
    do_op1(1'b1, 8'h00, 8'hFF);
    do_op1(1'b0, 8'hFF, 8'h01);
    do_op1(1'b1, 8'h5A, 8'h5A);
    for (int i = 0; i < 12; i++) begin
      do_op1(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    // Drain outstanding expectations.
    begin
      int n = 0;
      while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    @(posedge clk); #1;
    chk("u0_drain", exp_q.size(), 0);
    chk("u1_drain", exp1_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
